// File: rtl/metaball_field.sv
// ============================================================================
// metaball_field
// ----------------------------------------------------------------------------
// Renders NUM_BALLS bouncing balls as one summed, thresholded field. Two balls
// that come close merge into one blob. The block sits between the VGA timing
// generator and the output pins. It delays display and both syncs by the same
// three clocks as rgb, so every output stays aligned with the others.
//
// Ports
//   clk_100mhz   in   1  system clock
//   reset        in   1  synchronous, active-high reset
//   x            in  10  pixel column from the timing generator
//   y            in  10  pixel row from the timing generator
//   display_in   in   1  visible-area flag
//   h_sync_in    in   1  active-low horizontal sync
//   v_sync_in    in   1  active-low vertical sync; its falling edge moves the balls
//   rgb          out  1  lit pixel, already gated by display
//   display_out  out  1  display_in delayed by 3 clocks
//   h_sync_out   out  1  h_sync_in delayed by 3 clocks
//   v_sync_out   out  1  v_sync_in delayed by 3 clocks
//   pause        in   1  (only with METABALL_FIELD_PAUSE_EN) freezes ball motion
//
// Optional build macro: METABALL_FIELD_PAUSE_EN adds the pause input.
// ============================================================================
module metaball_field #(
    parameter int NUM_BALLS     = 4,
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int RADIUS        = 40,
    parameter int THRESHOLD     = 800,
    parameter int BALL_SPEED    = 5,
    parameter int START_X       = 100,
    parameter int START_Y       = 100,
    parameter int SPACING_X     = 60,
    parameter int SPACING_Y     = 40
) (
`ifdef METABALL_FIELD_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       clk_100mhz,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       display_in,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    output logic       rgb,
    output logic       display_out,
    output logic       h_sync_out,
    output logic       v_sync_out
);

    localparam int R_SQ  = RADIUS * RADIUS;
    localparam int C_W   = $clog2(R_SQ + 1);
    localparam int S_W   = C_W + $clog2(NUM_BALLS + 1);
    localparam int X_MIN = RADIUS;
    localparam int X_MAX = SCREEN_WIDTH - 1 - RADIUS;
    localparam int Y_MIN = RADIUS;
    localparam int Y_MAX = SCREEN_HEIGHT - 1 - RADIUS;

    // ------------------------------------------------------------------
    // Ball state. A direction bit of 1 means moving toward larger coordinates.
    // ------------------------------------------------------------------
    logic [9:0]           bx_q [NUM_BALLS];
    logic [9:0]           bx_d [NUM_BALLS];
    logic [9:0]           by_q [NUM_BALLS];
    logic [9:0]           by_d [NUM_BALLS];
    logic [NUM_BALLS-1:0] dir_x_q;
    logic [NUM_BALLS-1:0] dir_x_d;
    logic [NUM_BALLS-1:0] dir_y_q;
    logic [NUM_BALLS-1:0] dir_y_d;

    logic v_sync_prev_q;
    logic v_sync_prev_d;
    logic tick;

    // ------------------------------------------------------------------
    // Pipeline state. Index 0 of the sideband vectors is stage 1 and index 2
    // is stage 3, which drives the outputs directly.
    // ------------------------------------------------------------------
    logic [9:0]     dx_q [NUM_BALLS];
    logic [9:0]     dx_d [NUM_BALLS];
    logic [9:0]     dy_q [NUM_BALLS];
    logic [9:0]     dy_d [NUM_BALLS];
    logic [20:0]    d2   [NUM_BALLS];
    logic [C_W-1:0] c_q  [NUM_BALLS];
    logic [C_W-1:0] c_d  [NUM_BALLS];
    logic [S_W-1:0] field_sum;
    logic           pix;

    logic [2:0] display_q;
    logic [2:0] display_d;
    logic [2:0] h_sync_q;
    logic [2:0] h_sync_d;
    logic [2:0] v_sync_q;
    logic [2:0] v_sync_d;
    logic       rgb_q;
    logic       rgb_d;

    // ------------------------------------------------------------------
    // Frame tick on the falling edge of v_sync. The edge detector resets to 0.
    // A v_sync that is already low when reset is released therefore cannot
    // move the balls.
    // ------------------------------------------------------------------
    always_comb begin
        v_sync_prev_d = v_sync_in;
`ifdef METABALL_FIELD_PAUSE_EN
        tick = v_sync_prev_q & ~v_sync_in & ~pause;
`else
        tick = v_sync_prev_q & ~v_sync_in;
`endif
    end

    // ------------------------------------------------------------------
    // Ball motion. The checks are done in 11 bits so that pos + BALL_SPEED
    // cannot wrap. A ball that would overshoot a bound is clamped onto the
    // bound, and its direction flips on that same tick.
    // ------------------------------------------------------------------
    always_comb begin
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        for (int i = 0; i < NUM_BALLS; i++) begin
            bx_d[i] = bx_q[i];
            by_d[i] = by_q[i];
            if (tick) begin
                if (dir_x_q[i]) begin
                    if ({1'b0, bx_q[i]} + 11'(BALL_SPEED) >= 11'(X_MAX)) begin
                        bx_d[i]    = 10'(X_MAX);
                        dir_x_d[i] = 1'b0;
                    end else begin
                        bx_d[i] = bx_q[i] + 10'(BALL_SPEED);
                    end
                end else begin
                    if ({1'b0, bx_q[i]} <= 11'(X_MIN + BALL_SPEED)) begin
                        bx_d[i]    = 10'(X_MIN);
                        dir_x_d[i] = 1'b1;
                    end else begin
                        bx_d[i] = bx_q[i] - 10'(BALL_SPEED);
                    end
                end
                if (dir_y_q[i]) begin
                    if ({1'b0, by_q[i]} + 11'(BALL_SPEED) >= 11'(Y_MAX)) begin
                        by_d[i]    = 10'(Y_MAX);
                        dir_y_d[i] = 1'b0;
                    end else begin
                        by_d[i] = by_q[i] + 10'(BALL_SPEED);
                    end
                end else begin
                    if ({1'b0, by_q[i]} <= 11'(Y_MIN + BALL_SPEED)) begin
                        by_d[i]    = 10'(Y_MIN);
                        dir_y_d[i] = 1'b1;
                    end else begin
                        by_d[i] = by_q[i] - 10'(BALL_SPEED);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 samples the ball positions as they stand before this edge's
    // update. A tick therefore only moves the balls for pixels entering
    // the pipeline after it.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_BALLS; i++) begin
            dx_d[i] = (x >= bx_q[i]) ? (x - bx_q[i]) : (bx_q[i] - x);
            dy_d[i] = (y >= by_q[i]) ? (y - by_q[i]) : (by_q[i] - y);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 computes the per-ball contribution. Each square of a 10-bit
    // value fits in 20 bits, and the sum of two squares is kept at 21 bits
    // so that nothing is truncated.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_BALLS; i++) begin
            d2[i] = {1'b0, {10'd0, dx_q[i]} * {10'd0, dx_q[i]}}
                  + {1'b0, {10'd0, dy_q[i]} * {10'd0, dy_q[i]}};
            if (d2[i] < 21'(R_SQ)) begin
                c_d[i] = C_W'(21'(R_SQ) - d2[i]);
            end else begin
                c_d[i] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3 sums the contributions, applies the threshold and gates the
    // result by display. The threshold compare is done in 32 bits, so a
    // THRESHOLD above the largest possible sum simply never lights a pixel.
    // ------------------------------------------------------------------
    always_comb begin
        field_sum = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            field_sum = field_sum + S_W'(c_q[i]);
        end
        pix   = ({{(32-S_W){1'b0}}, field_sum} >= 32'(THRESHOLD));
        rgb_d = display_q[1] & pix;

        display_d = {display_q[1:0], display_in};
        h_sync_d  = {h_sync_q[1:0],  h_sync_in};
        v_sync_d  = {v_sync_q[1:0],  v_sync_in};
    end

    // ------------------------------------------------------------------
    // State registers. Reset is synchronous. It wins over a tick that lands
    // on the same edge, so the balls simply return to their start positions.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                bx_q[i]    <= 10'(START_X + i * SPACING_X);
                by_q[i]    <= 10'(START_Y + i * SPACING_Y);
                dir_x_q[i] <= ((i % 2) == 0);
                dir_y_q[i] <= (((i / 2) % 2) == 0);
                dx_q[i]    <= '0;
                dy_q[i]    <= '0;
                c_q[i]     <= '0;
            end
            v_sync_prev_q <= 1'b0;
            display_q     <= '0;
            h_sync_q      <= '1;
            v_sync_q      <= '1;
            rgb_q         <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                bx_q[i] <= bx_d[i];
                by_q[i] <= by_d[i];
                dx_q[i] <= dx_d[i];
                dy_q[i] <= dy_d[i];
                c_q[i]  <= c_d[i];
            end
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            v_sync_prev_q <= v_sync_prev_d;
            display_q     <= display_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            rgb_q         <= rgb_d;
        end
    end

    assign rgb         = rgb_q;
    assign display_out = display_q[2];
    assign h_sync_out  = h_sync_q[2];
    assign v_sync_out  = v_sync_q[2];

endmodule

// File: doc/metaball_field.md
# metaball_field

Parametrised, fully synchronous metaball renderer for the VGA pipeline, clocked from clk_100mhz. It renders NUM_BALLS bouncing balls as a summed, thresholded field, so balls that come close merge visually. It sits between the VGA timing generator and the output pins. The block delays sync and display by the same fixed latency as rgb, so all outputs stay aligned.

## Interface
- NUM_BALLS, 4: number of balls, 1..8.
- SCREEN_WIDTH, 800: visible width in pixels.
- SCREEN_HEIGHT, 600: visible height in lines.
- RADIUS, 40: field radius; R_SQ = RADIUS*RADIUS.
- THRESHOLD, 800: pixel lit when field sum >= THRESHOLD.
- BALL_SPEED, 5: pixels moved per frame per axis.
- START_X, 100 / START_Y, 100: reset position of ball 0.
- SPACING_X, 60 / SPACING_Y, 40: position offset per ball index.
- clk_100mhz  in  1: clock.
- reset  in  1: reset, synchronous, active-high. Clock is clk_100mhz.
- x  in  10: pixel column from the VGA timing generator.
- y  in  10: pixel row from the VGA timing generator.
- display_in  in  1: visible-area flag.
- h_sync_in  in  1: active-low horizontal sync.
- v_sync_in  in  1: active-low vertical sync.
- rgb  out  1: pixel value, already gated by display.
- display_out  out  1: display_in delayed by 3 clocks.
- h_sync_out  out  1: h_sync_in delayed by 3 clocks.
- v_sync_out  out  1: v_sync_in delayed by 3 clocks.

## Operation
- Ball i reset state:
  - position (START_X + i*SPACING_X, START_Y + i*SPACING_Y).
  - vx positive for even i, negative for odd i.
  - vy positive when i[1]=0, negative otherwise.
- Motion bounds: X_MIN = RADIUS, X_MAX = SCREEN_WIDTH-1-RADIUS; Y_MIN and Y_MAX are defined the same way with SCREEN_HEIGHT.
- Frame tick:
  - v_sync_prev is a register updated every clock; its reset value is 0.
  - tick = v_sync_prev & ~v_sync_in, i.e. the falling edge of sync.
  - Exactly one tick per frame. No spurious tick out of reset.
- On tick, each axis of each ball updates independently:
  - Moving positive, pos + BALL_SPEED >= MAX: pos <= MAX and the direction flips to negative.
  - Moving negative, pos <= MIN + BALL_SPEED: pos <= MIN and the direction flips to positive.
  - Otherwise: pos <= pos ± BALL_SPEED.
- Field per ball:
  - dx = |x - bx| and dy = |y - by|, each 10 bits unsigned.
  - d2 = dx*dx + dy*dy, 21 bits, no truncation.
  - c_i = (d2 < R_SQ) ? R_SQ - d2 : 0.
- Sum:
  - S = Σ c_i, width clog2(R_SQ+1) + clog2(NUM_BALLS+1), so it cannot overflow.
  - pix = (S >= THRESHOLD).
  - rgb = display_d3 & pix.
- Ball positions are sampled at pipeline stage 1. A tick changes only the positions used by later pixels.

## Timing
- Latency: 3 clk_100mhz cycles from any input to every output. Throughput is one sample per clock.
- The 50 MHz pixel rate (x held for 2 clocks) needs no special handling. Each pixel yields 2 identical outputs.
- Pipeline stages:
  - S1 registers dx, dy and the delayed display/sync.
  - S2 registers the c_i values.
  - S3 registers rgb and the delayed display/sync.
- Reset values: rgb=0, display_out=0, h_sync_out=1, v_sync_out=1.
  - All pipeline sync registers reset to 1.
  - All display and field registers reset to 0.
  - Balls return to their reset state.
- Reset mid-frame takes effect on the next clock edge. Outputs hold their reset values while reset is high.
- Tick coinciding with reset: reset wins and no motion occurs.

## Configuration
- METABALL_FIELD_PAUSE_EN defined:
  - Adds port pause, input, 1 bit.
  - While pause=1, ticks are ignored and positions and directions hold.
  - Rendering continues.
- Not defined: the port is absent and balls move on every tick.

## Test plan
- Reset, then x=0, y=0, display_in=1, h_sync_in=0 held -> all outputs show reset values during reset. Three clocks after release: h_sync_out=0 and display_out=1.
- NUM_BALLS=1, ball at (100,100), pixel (100,100) -> rgb=1 three clocks later. Pixel (130,100) gives d2=900, c=700 -> rgb=0.
- NUM_BALLS=2, SPACING_X=60, SPACING_Y=0, pixel (130,100) -> each c=700, S=1400 -> rgb=1, showing the merge.
- display_in=0 at pixel (100,100) -> rgb=0 despite pix=1.
- START_X = X_MAX-2 (757), moving positive, apply ticks -> x=759, then 754, then 749.
  - A v_sync_in held low for 6 lines produces exactly one step.
- With METABALL_FIELD_PAUSE_EN and pause=1 over 3 frames -> position unchanged. After pause=0, the next tick moves the ball by 5.
